// File: rtl/regfile_fwd.sv
// 31x32 register file (x0 hardwired to zero) with write-through and, when
// REGFILE_FORWARD_EN is defined, EX/MEM operand forwarding plus load-use stall detection.
module regfile_fwd (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic        re1_i,
   input  logic [4:0]  raddr1_i,
   input  logic        re2_i,
   input  logic [4:0]  raddr2_i,
   input  logic        ex_wreg_i,
   input  logic [4:0]  ex_wd_i,
   input  logic [31:0] ex_wdata_i,
   input  logic        ex_is_load_i,
   input  logic        mem_wreg_i,
   input  logic [4:0]  mem_wd_i,
   input  logic [31:0] mem_wdata_i,
   output logic [31:0] rdata1_o,
   output logic [31:0] rdata2_o,
   output logic        stallreq_o
);

   logic [31:0] regs_q [1:31];
   logic [31:0] regs_d [1:31];

   logic        ex_fwd_ok;
   logic        mem_fwd_ok;
   logic        load_haz;

`ifdef REGFILE_FORWARD_EN
   // A load in EX has no data yet: it stalls instead of forwarding, and the
   // port falls through to the next source so the output is still defined.
   assign ex_fwd_ok  = ex_wreg_i & ~ex_is_load_i;
   assign mem_fwd_ok = mem_wreg_i;
   assign load_haz   = ex_wreg_i & ex_is_load_i & (ex_wd_i != 5'd0);
`else
   logic unused_fwd;
   assign unused_fwd = ^{ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i,
                         mem_wreg_i, mem_wd_i, mem_wdata_i};
   assign ex_fwd_ok  = 1'b0;
   assign mem_fwd_ok = 1'b0;
   assign load_haz   = 1'b0;
`endif

   always_comb begin
      regs_d = regs_q;
      for (int i = 1; i < 32; i++) begin
         if (we_i && (waddr_i == 5'(i))) begin
            regs_d[i] = wdata_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 1; i < 32; i++) begin
            regs_q[i] <= 32'd0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   logic [4:0]  raddr [2];
   logic        re    [2];
   logic [31:0] rdata [2];

   assign raddr[0] = raddr1_i;
   assign raddr[1] = raddr2_i;
   assign re[0]    = re1_i;
   assign re[1]    = re2_i;

   // Later assignments override earlier ones, so sources are applied lowest
   // priority first: array, write-through, MEM, EX, then the zero cases.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata[p] = 32'd0;
         for (int i = 1; i < 32; i++) begin
            if (raddr[p] == 5'(i)) begin
               rdata[p] = regs_q[i];
            end
         end
         if (we_i && (waddr_i == raddr[p])) begin
            rdata[p] = wdata_i;
         end
         if (mem_fwd_ok && (mem_wd_i == raddr[p])) begin
            rdata[p] = mem_wdata_i;
         end
         if (ex_fwd_ok && (ex_wd_i == raddr[p])) begin
            rdata[p] = ex_wdata_i;
         end
         if (!rst || !re[p] || (raddr[p] == 5'd0)) begin
            rdata[p] = 32'd0;
         end
      end
   end

   assign rdata1_o   = rdata[0];
   assign rdata2_o   = rdata[1];
   assign stallreq_o = rst & load_haz &
                       ((re1_i & (raddr1_i == ex_wd_i)) | (re2_i & (raddr2_i == ex_wd_i)));

endmodule

// File: tb/tb_regfile_fwd.sv
// Directed + randomized bench for regfile_fwd against a behavioural model of the register file.
module tb_regfile_fwd;

`ifdef REGFILE_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        we_i;
   logic [4:0]  waddr_i;
   logic [31:0] wdata_i;
   logic        re1_i, re2_i;
   logic [4:0]  raddr1_i, raddr2_i;
   logic        ex_wreg_i;
   logic [4:0]  ex_wd_i;
   logic [31:0] ex_wdata_i;
   logic        ex_is_load_i;
   logic        mem_wreg_i;
   logic [4:0]  mem_wd_i;
   logic [31:0] mem_wdata_i;
   logic [31:0] rdata1_o, rdata2_o;
   logic        stallreq_o;

   int tests = 0;
   int fails = 0;
   logic [31:0] model_rf [32];

   regfile_fwd dut (
      .clk(clk), .rst(rst),
      .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
      .re1_i(re1_i), .raddr1_i(raddr1_i), .re2_i(re2_i), .raddr2_i(raddr2_i),
      .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
      .ex_is_load_i(ex_is_load_i),
      .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
      .rdata1_o(rdata1_o), .rdata2_o(rdata2_o), .stallreq_o(stallreq_o)
   );

   always #5 clk = ~clk;

   // Value a read port should return, following the source order of the block.
   function automatic logic [31:0] model_rd(input logic re, input logic [4:0] a);
      if (!rst || !re || a == 5'd0) return 32'd0;
      if (FWD && ex_wreg_i && !ex_is_load_i && ex_wd_i == a) return ex_wdata_i;
      if (FWD && mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
      if (we_i && waddr_i == a) return wdata_i;
      return model_rf[a];
   endfunction

   function automatic logic model_stall();
      logic hit;
      hit = (re1_i && raddr1_i == ex_wd_i) || (re2_i && raddr2_i == ex_wd_i);
      return FWD && rst && ex_is_load_i && ex_wreg_i && ex_wd_i != 5'd0 && hit;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_rd1"}, rdata1_o, model_rd(re1_i, raddr1_i));
      check({tag, "_rd2"}, rdata2_o, model_rd(re2_i, raddr2_i));
      check({tag, "_stall"}, {31'd0, stallreq_o}, {31'd0, model_stall()});
   endtask

   // Commit the pending write to the model, then advance past the edge.
   task automatic cyc();
      if (rst && we_i && waddr_i != 5'd0) model_rf[waddr_i] = wdata_i;
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      we_i = 0; waddr_i = 0; wdata_i = 0;
      re1_i = 0; raddr1_i = 0; re2_i = 0; raddr2_i = 0;
      ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
      mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
      idle();
      rst = 1'b0;

      // Reset: outputs forced low even with live requests, writes ignored.
      #3;
      we_i = 1; waddr_i = 5; wdata_i = 32'hDEAD_BEEF;
      re1_i = 1; raddr1_i = 5; re2_i = 1; raddr2_i = 5;
      ex_wreg_i = 1; ex_wd_i = 5; ex_is_load_i = 1;
      #1;
      check("rst_rd1", rdata1_o, 32'd0);
      check("rst_rd2", rdata2_o, 32'd0);
      check("rst_stall", {31'd0, stallreq_o}, 32'd0);
      cyc();
      idle();
      rst = 1'b1;

      // Reset and write.
      re1_i = 1; raddr1_i = 5;
      #1 check("x5_after_rst", rdata1_o, 32'd0);
      we_i = 1; waddr_i = 5; wdata_i = 32'h1234_5678;
      cyc();
      idle(); re1_i = 1; raddr1_i = 5;
      #1 check("x5_written", rdata1_o, 32'h1234_5678);

      // x0 ignores write-through and EX forwarding.
      idle();
      we_i = 1; waddr_i = 0; wdata_i = 32'hFFFF_FFFF;
      ex_wreg_i = 1; ex_wd_i = 0; ex_wdata_i = 32'hAAAA_0000;
      re1_i = 1; raddr1_i = 0; re2_i = 1; raddr2_i = 0;
      #1 check("x0_fwd", rdata1_o, 32'd0);
      check_all("x0");
      cyc();
      idle(); re1_i = 1; raddr1_i = 0;
      #1 check("x0_after", rdata1_o, 32'd0);

      // Priority EX > MEM > array.
      idle(); we_i = 1; waddr_i = 3; wdata_i = 32'h11;
      cyc();
      idle();
      re1_i = 1; raddr1_i = 3; re2_i = 1; raddr2_i = 3;
      mem_wreg_i = 1; mem_wd_i = 3; mem_wdata_i = 32'h22;
      ex_wreg_i = 1; ex_wd_i = 3; ex_wdata_i = 32'h33;
      #1 check("prio_ex", rdata1_o, FWD ? 32'h33 : 32'h11);
      check("prio_same_reg", rdata2_o, FWD ? 32'h33 : 32'h11);
      ex_wreg_i = 0;
      #1 check("prio_mem", rdata1_o, FWD ? 32'h22 : 32'h11);
      mem_wreg_i = 0;
      #1 check("prio_arr", rdata1_o, 32'h11);

      // Load-use stall on port 2.
      idle();
      ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = 7; ex_wdata_i = 32'h7777;
      re2_i = 1; raddr2_i = 7;
      #1 check("ld_stall", {31'd0, stallreq_o}, {31'd0, FWD});
      check_all("ld_use");
      re2_i = 0;
      #1 check("ld_re0", {31'd0, stallreq_o}, 32'd0);
      re2_i = 1; raddr2_i = 8;
      #1 check("ld_addr8", {31'd0, stallreq_o}, 32'd0);

      // Write-through before the edge.
      idle();
      we_i = 1; waddr_i = 9; wdata_i = 32'hCAFE_F00D; re1_i = 1; raddr1_i = 9;
      #1 check("wthru", rdata1_o, 32'hCAFE_F00D);
      cyc();

      // Asynchronous reset in the middle of a write.
      idle(); we_i = 1; waddr_i = 4; wdata_i = 32'h5;
      cyc();
      idle(); we_i = 1; waddr_i = 4; wdata_i = 32'h6; re1_i = 1; raddr1_i = 4;
      #1 check("x4_pending", rdata1_o, 32'h6);
      #1 rst = 1'b0;
      for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
      #1 check("x4_in_rst", rdata1_o, 32'd0);
      @(posedge clk);
      #2 rst = 1'b1;
      we_i = 0;
      #1 check("x4_after_rst", rdata1_o, 32'd0);
      check("x5_after_rst2", model_rd(1'b1, 5'd5), 32'd0);
      re2_i = 1; raddr2_i = 5;
      #1 check("x5_cleared", rdata2_o, 32'd0);

      // Randomized traffic on a narrow address range to force collisions.
      for (int n = 0; n < 400; n++) begin
         we_i = 1'($urandom); waddr_i = 5'($urandom_range(0, 7)); wdata_i = $urandom;
         re1_i = ($urandom_range(0, 7) != 0); raddr1_i = 5'($urandom_range(0, 7));
         re2_i = ($urandom_range(0, 7) != 0); raddr2_i = 5'($urandom_range(0, 7));
         ex_wreg_i = 1'($urandom); ex_wd_i = 5'($urandom_range(0, 7)); ex_wdata_i = $urandom;
         ex_is_load_i = 1'($urandom);
         mem_wreg_i = 1'($urandom); mem_wd_i = 5'($urandom_range(0, 7)); mem_wdata_i = $urandom;
         #1 check_all("rand");
         cyc();
      end

      // Final sweep of the whole array through both ports.
      idle();
      for (int a = 0; a < 32; a++) begin
         re1_i = 1; raddr1_i = 5'(a); re2_i = 1; raddr2_i = 5'(31 - a);
         #1 check_all("sweep");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/regfile_fwd.md
REGFILE_FWD -- requirements
Module: regfile_fwd

Interface
REQ-001 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1, the reset: asynchronous, active-low.
REQ-003 The block SHALL have port we_i, input, 1, the write-back write enable.
REQ-004 The block SHALL have port waddr_i, input, 5, the write-back destination register.
REQ-005 The block SHALL have port wdata_i, input, 32, the write-back data.
REQ-006 The block SHALL have ports re1_i and re2_i, input, 1 each, the read enables for ports 1 and 2.
REQ-007 The block SHALL have ports raddr1_i and raddr2_i, input, 5 each, the read addresses.
REQ-008 The block SHALL have ports ex_wreg_i (1), ex_wd_i (5) and ex_wdata_i (32), all inputs, carrying the EX-stage forwarding result.
REQ-009 The block SHALL have input ex_is_load_i, 1, which marks the EX-stage instruction as a load, whose data is not yet valid.
REQ-010 The block SHALL have ports mem_wreg_i (1), mem_wd_i (5) and mem_wdata_i (32), all inputs, carrying the MEM-stage forwarding result.
REQ-011 The block SHALL have outputs rdata1_o and rdata2_o, 32 each, the resolved operand values.
REQ-012 The block SHALL have output stallreq_o, 1, the load-use stall request to the pipeline controller.

Function
REQ-013 The block SHALL hold 31 registers, x1..x31, each 32 bits wide; x0 SHALL always read 0 and writes to x0 SHALL be discarded.
REQ-014 When we_i=1 and waddr_i!=0, the block SHALL write wdata_i into x[waddr_i] on the rising edge of clk.
REQ-015 Reads SHALL be combinational, with zero-cycle latency from address to data.
REQ-016 When re_i=0, the corresponding rdata_o SHALL be 0.
REQ-017 A read from address 0 SHALL return 0 regardless of any forwarding source.
REQ-018 For each port, the read priority SHALL be, highest first: EX match (ex_wreg_i=1 and ex_wd_i=raddr), then MEM match, then a same-cycle write-back match (we_i=1 and waddr_i=raddr, write-through), then the array contents.
REQ-019 stallreq_o SHALL be 1 when ex_is_load_i=1, ex_wreg_i=1, ex_wd_i!=0, and ex_wd_i equals a read address whose read enable is 1; otherwise stallreq_o SHALL be 0.
REQ-020 While stallreq_o=1, the rdata_o of the affected port SHALL still be driven, with the value taken from the next-lower priority source; the consumer discards it.
REQ-021 If both ports read the same register, each SHALL resolve it independently and return identical values.
REQ-022 If EX and MEM target the same register simultaneously, the EX value SHALL win.
REQ-023 A write-back on the same edge as a read of the same register SHALL make the new value visible combinationally in the same cycle.

Reset
REQ-024 While rst=0, x1..x31 SHALL be cleared to 0 immediately, without waiting for a clock edge.
REQ-025 While rst=0, writes SHALL be ignored, rdata1_o and rdata2_o SHALL be 0, and stallreq_o SHALL be 0.
REQ-026 When rst rises to 1, the next rising edge of clk SHALL be able to write.
REQ-027 A reset asserted in the middle of a write cycle SHALL leave the target register at 0.

Configuration
REQ-028 The block SHALL have one configuration macro, REGFILE_FORWARD_EN.
REQ-029 With REGFILE_FORWARD_EN defined, EX/MEM forwarding (REQ-018) and load-use stall detection (REQ-019) SHALL be active.
REQ-030 With REGFILE_FORWARD_EN undefined:
- the ex_* and mem_* inputs SHALL be ignored;
- the read priority SHALL be write-through, then the array;
- stallreq_o SHALL be tied to 0.

Verification
REQ-031 Reset and write: pulse rst=0, then read x5, which SHALL return 0; write x5=0x12345678 with we_i=1; on the next cycle, a read of x5 SHALL return 0x12345678.
REQ-032 x0: write x0=0xFFFFFFFF with ex_wd_i=0, ex_wreg_i=1 and ex_wdata_i=0xAAAA0000; a read of x0 SHALL return 0x00000000.
REQ-033 Priority: set x3=0x11, MEM drives x3=0x22 and EX drives x3=0x33 in the same cycle; rdata1_o SHALL be 0x33; with EX removed it SHALL be 0x22; with MEM also removed it SHALL be 0x11.
REQ-034 Load-use: ex_is_load_i=1, ex_wreg_i=1, ex_wd_i=7, raddr2_i=7, re2_i=1 SHALL give stallreq_o=1; with re2_i=0 or raddr2_i=8, stallreq_o SHALL be 0.
REQ-035 Write-through: we_i=1, waddr_i=9, wdata_i=0xCAFEF00D, raddr1_i=9 in the same cycle SHALL give rdata1_o=0xCAFEF00D before the clock edge.
REQ-036 Asynchronous reset: with x4 holding 0x5 and a write to x4=0x6 pending, assert rst=0 between clock edges; x4 SHALL read 0 immediately and SHALL remain 0 after release.
